interboard_tx_scheduler: RTL and testbench
==========================================

# interboard_tx_scheduler

Arbitrates between two message sources that share the single interboard transmitter (the `InterboardCommunication_top` ctrl port) and sequences each transfer through its transmit/ready handshake.
- Each source pushes (msg_type, number) pairs into its own FIFO.
- The scheduler grants the sources round-robin and drives `transmit`/`ctrl_*`.
- It waits for the transmitter to go busy and then return ready, retrying any transfer whose ready does not come back within a timeout.
- It sits between `Game_Master` (requester 0), an auxiliary source such as the keyboard or echo path (requester 1), and the interboard link.

## Interface
Parameters:
- DEPTH, 4: entries per requester FIFO; power of two, ≥2.
- TIMEOUT, 1_000_000: cycles allowed per handshake wait before a retry; ≥2.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- interboard_rst  in  1  synchronous, active-high flush from the interboard link.
- req0_valid  in  1  requester 0 has a message.
- req0_msg_type  in  3  requester 0 message type.
- req0_number  in  5  requester 0 number.
- req0_ready  out  1  FIFO 0 not full.
- req1_valid, req1_msg_type, req1_number, req1_ready: same as requester 0, for requester 1.
- inter_ready  in  1  transmitter idle; 0 while a transfer is in flight.
- transmit  out  1  one-cycle start pulse to the transmitter.
- ctrl_en  out  1  ctrl fields valid.
- ctrl_msg_type  out  3  message type being sent.
- ctrl_number  out  5  number being sent.
- busy  out  1  FSM not in IDLE.
- timeout_err  out  1  one-cycle pulse on each timeout.
- grant  out  1  requester currently being served; meaningful while busy.

## Operation
FIFOs:
- Push on `reqN_valid & reqN_ready`, where `reqN_ready = (count != DEPTH)`.
- A full FIFO refuses a push even if a pop happens in the same cycle.
- A simultaneous push and pop on a non-full FIFO leaves count unchanged.
- Pointers wrap modulo DEPTH. The count is log2(DEPTH)+1 bits wide.

Arbitration (`last` register, reset 1):
- If exactly one FIFO is non-empty, grant it.
- If both are non-empty, grant the requester that is not `last`.
- `last` updates only when a transfer completes.

FSM:
- IDLE → ISSUE when `inter_ready = 1` and any FIFO is non-empty. The grant and the head entry are latched into output registers on this transition.
- ISSUE: `transmit = 1` for exactly one cycle. Next state is WAIT_LOW.
- WAIT_LOW: wait for `inter_ready = 0`, then go to WAIT_HIGH.
- WAIT_HIGH: wait for `inter_ready = 1`. On it, pop the granted FIFO, set `last = grant`, and go to IDLE.
- Timeout: a cycle counter clears on entry to ISSUE and counts during WAIT_LOW and WAIT_HIGH. When it reaches TIMEOUT-1 without the awaited edge:
  - pulse `timeout_err`;
  - go to IDLE without popping and without changing `last`.
  - The same entry is then re-issued as soon as `inter_ready = 1`, except that the arbiter may legally pick the other FIFO, since `last` is unchanged.
- `ctrl_en` is high from ISSUE through WAIT_HIGH. `ctrl_msg_type`, `ctrl_number` and `grant` hold constant for the whole transfer.

`interboard_rst` (or `rst`) at any time:
- empties both FIFOs;
- sets FSM = IDLE, counter = 0, `last` = 1;
- drops `transmit` and `ctrl_en` in the next cycle.
- A transfer aborted mid-flight is lost, not retried.

## Timing
- Reset values: `transmit = 0`, `ctrl_en = 0`, `ctrl_msg_type = 0`, `ctrl_number = 0`, `busy = 0`, `timeout_err = 0`, `grant = 0`, `req0_ready = 1`, `req1_ready = 1`.
- Latency: with the FSM in IDLE and `inter_ready = 1`, a push in cycle N gives `transmit = 1` in cycle N+2.
- Handshake:
  - `inter_ready` dropping in the ISSUE cycle itself is not counted; the drop is only sampled from WAIT_LOW onward.
  - The pop is visible in `reqN_ready` and the FIFO count one cycle after `inter_ready` is sampled high in WAIT_HIGH.
- Back-to-back: IDLE lasts at least 1 cycle between transfers, so the minimum spacing is 4 cycles (ISSUE, WAIT_LOW, WAIT_HIGH, IDLE) plus transmitter busy time.
- All outputs are registered. There is no combinational path from inputs to outputs except `reqN_ready`, which depends on the FIFO count only.

## Test plan
- Single message: push req0 {type 3, num 17}; model drops `inter_ready` 1 cycle after `transmit` and raises it after 10 cycles.
  -> `transmit` at N+2; `ctrl_en = 1`, `ctrl_msg_type = 3`, `ctrl_number = 17` throughout; FIFO0 empty afterwards.
- Round-robin: preload 2 entries in each FIFO before the link is ready.
  -> send order is req0, req1, req0, req1; `grant` = 0, 1, 0, 1.
- Full and wrap: with the link stalled, push DEPTH entries to req1.
  -> `req1_ready = 0` and the extra push is refused. Release the link and push 3 more: all entries come out in FIFO order across the pointer wrap.
- Timeout: with TIMEOUT = 8, `inter_ready` never drops.
  -> `timeout_err` pulses 8 cycles after ISSUE; the same entry is re-issued; no pop occurs. The model then responds normally and the transfer completes.
- Flush: assert `interboard_rst` in WAIT_HIGH with 3 entries queued.
  -> next cycle `ctrl_en = 0`, `busy = 0`, both FIFOs empty, no further `transmit`.
- Async reset: drop `rst` mid-ISSUE.
  -> `transmit` goes to 0 immediately, without waiting for a clock edge; all outputs take their reset values.

Source files
------------

// File: rtl/interboard_tx_scheduler.sv
// interboard_tx_scheduler: round-robin scheduler feeding two message
// FIFOs into the shared interboard transmitter, with handshake retry.
//
// clk, rst        : clock, asynchronous active-low reset
// interboard_rst  : synchronous flush from the interboard link
// req0_*, req1_*  : per-source push ports; reqN_ready = FIFO not full
// inter_ready     : transmitter idle (0 while a transfer is in flight)
// transmit        : one-cycle start pulse
// ctrl_en/_msg_type/_number : fields of the transfer in progress
// busy, timeout_err, grant  : scheduler status
module interboard_tx_scheduler #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       interboard_rst,
  input  logic       req0_valid,
  input  logic [2:0] req0_msg_type,
  input  logic [4:0] req0_number,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [2:0] req1_msg_type,
  input  logic [4:0] req1_number,
  output logic       req1_ready,
  input  logic       inter_ready,
  output logic       transmit,
  output logic       ctrl_en,
  output logic [2:0] ctrl_msg_type,
  output logic [4:0] ctrl_number,
  output logic       busy,
  output logic       timeout_err,
  output logic       grant
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = AW + 1;
  localparam int CW   = $clog2(TIMEOUT);

  localparam logic [CNTW-1:0] FULL    = CNTW'(DEPTH);
  localparam logic [CW-1:0]   TO_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_LOW,
    WAIT_HIGH
  } state_t;

  state_t        state;
  logic [CW-1:0] tcnt;
  logic [CW-1:0] tnext;
  logic          last;

  logic [7:0]      mem  [2][DEPTH];
  logic [AW-1:0]   wp   [2];
  logic [AW-1:0]   rp   [2];
  logic [CNTW-1:0] fcnt [2];
  logic [7:0]      din  [2];
  logic [7:0]      head [2];

  logic [1:0] push;
  logic [1:0] pop;
  logic [1:0] ne;
  logic [1:0] rdy;
  logic       sel;
  logic       done;
  logic       fire;
  logic       to_hit;

  assign din[0] = {req0_msg_type, req0_number};
  assign din[1] = {req1_msg_type, req1_number};

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      rdy[i]  = fcnt[i] != FULL;
      ne[i]   = fcnt[i] != '0;
      head[i] = mem[i][rp[i]];
    end
  end

  assign req0_ready = rdy[0];
  assign req1_ready = rdy[1];

  // A full FIFO refuses a push even when it pops the same cycle.
  assign push = {req1_valid, req0_valid} & rdy;

  assign done = (state == WAIT_HIGH) && inter_ready;
  assign pop  = {done & grant, done & ~grant};
  assign fire = (state == IDLE) && inter_ready && (|ne);

  // Counter holds at the limit so a late edge cannot wrap it.
  assign to_hit = tcnt == TO_LAST;
  assign tnext  = to_hit ? tcnt : tcnt + CW'(1);

  always_comb begin
    sel = 1'b0;
    unique case (1'b1)
      ne[0] & ne[1]:  sel = ~last;
      ne[1] & ~ne[0]: sel = 1'b1;
      default:        sel = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (push[i]) mem[i][wp[i]] <= din[i];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        wp[i]   <= '0;
        rp[i]   <= '0;
        fcnt[i] <= '0;
      end
    end else if (interboard_rst) begin
      for (int i = 0; i < 2; i++) begin
        wp[i]   <= '0;
        rp[i]   <= '0;
        fcnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (push[i]) wp[i] <= wp[i] + AW'(1);
        if (pop[i])  rp[i] <= rp[i] + AW'(1);
        fcnt[i] <= fcnt[i]
                 + CNTW'(push[i])
                 - CNTW'(pop[i]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      tcnt          <= '0;
      last          <= 1'b1;
      transmit      <= 1'b0;
      ctrl_en       <= 1'b0;
      ctrl_msg_type <= '0;
      ctrl_number   <= '0;
      busy          <= 1'b0;
      timeout_err   <= 1'b0;
      grant         <= 1'b0;
    end else if (interboard_rst) begin
      state       <= IDLE;
      tcnt        <= '0;
      last        <= 1'b1;
      transmit    <= 1'b0;
      ctrl_en     <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      transmit    <= 1'b0;
      timeout_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (fire) begin
            state <= ISSUE;
            tcnt  <= '0;
            transmit <= 1'b1;
            ctrl_en  <= 1'b1;
            busy     <= 1'b1;
            grant    <= sel;
            {ctrl_msg_type, ctrl_number} <= head[sel];
          end
        end
        ISSUE: begin
          state <= WAIT_LOW;
          tcnt  <= tnext;
        end
        WAIT_LOW: begin
          if (!inter_ready) begin
            state <= WAIT_HIGH;
            tcnt  <= tnext;
          end else if (to_hit) begin
            state       <= IDLE;
            ctrl_en     <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b1;
          end else begin
            tcnt <= tnext;
          end
        end
        WAIT_HIGH: begin
          if (inter_ready) begin
            state   <= IDLE;
            last    <= grant;
            ctrl_en <= 1'b0;
            busy    <= 1'b0;
          end else if (to_hit) begin
            state       <= IDLE;
            ctrl_en     <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b1;
          end else begin
            tcnt <= tnext;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_interboard_tx_scheduler.sv
// tb_interboard_tx_scheduler: randomized self-checking bench with a
// timestamped queue model of the two FIFOs and the round-robin rule.
module tb_interboard_tx_scheduler;

  localparam int DEPTH = 4;
  localparam int TO    = 8;

  typedef struct {
    logic [7:0] d;
    int         av;
  } ent_t;

  logic       clk = 0;
  logic       rst = 0;
  logic       irst = 0;
  logic       inter_ready = 0;
  logic       req0_valid = 0;
  logic [2:0] req0_msg_type = 0;
  logic [4:0] req0_number = 0;
  logic       req1_valid = 0;
  logic [2:0] req1_msg_type = 0;
  logic [4:0] req1_number = 0;
  logic       req0_ready, req1_ready;
  logic       transmit, ctrl_en, busy;
  logic       timeout_err, grant;
  logic [2:0] ctrl_msg_type;
  logic [4:0] ctrl_number;

  ent_t       q0[$];
  ent_t       q1[$];
  bit         mlast = 1;
  logic [8:0] sent[$];
  int cyc = 0, total = 0, bad = 0;
  int done_cnt = 0, to_seen = 0, to_left = 0;
  bit link_en = 0;

  interboard_tx_scheduler #(
    .DEPTH(DEPTH),
    .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .interboard_rst(irst),
    .req0_valid(req0_valid),
    .req0_msg_type(req0_msg_type),
    .req0_number(req0_number),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid),
    .req1_msg_type(req1_msg_type),
    .req1_number(req1_number),
    .req1_ready(req1_ready),
    .inter_ready(inter_ready),
    .transmit(transmit),
    .ctrl_en(ctrl_en),
    .ctrl_msg_type(ctrl_msg_type),
    .ctrl_number(ctrl_number),
    .busy(busy),
    .timeout_err(timeout_err),
    .grant(grant)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  // Transmitter model: answers each start pulse and keeps the
  // reference queues in step with completed transfers.
  task automatic serve();
    int t, g, b;
    bit n0, n1;
    logic [7:0] e;
    t  = cyc;
    n0 = q0.size() > 0 && q0[0].av <= t - 1;
    n1 = q1.size() > 0 && q1[0].av <= t - 1;
    total++;
    if (!n0 && !n1) begin
      bad++;
      $display("FAIL spurious_tx cyc=%0d", t);
      return;
    end
    g = (n0 && n1) ? (mlast ? 0 : 1) : (n0 ? 0 : 1);
    e = g ? q1[0].d : q0[0].d;
    total++;
    if (grant !== g[0]) begin
      bad++;
      $display("FAIL tx_grant got=%b want=%0d", grant, g);
    end
    total++;
    if ({ctrl_msg_type, ctrl_number} !== e) begin
      bad++;
      $display("FAIL tx_fields got=%h want=%h",
               {ctrl_msg_type, ctrl_number}, e);
    end
    total++;
    if (ctrl_en !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL tx_en got=%b%b want=11", ctrl_en, busy);
    end
    sent.push_back({g[0], e});
    if (to_left > 0) begin
      repeat (TO - 1) begin
        @(negedge clk);
        total++;
        if (timeout_err !== 1'b0 || ctrl_en !== 1'b1 ||
            transmit !== 1'b0 ||
            {ctrl_msg_type, ctrl_number} !== e) begin
          bad++;
          $display("FAIL to_hold err=%b en=%b tx=%b want 0 1 0",
                   timeout_err, ctrl_en, transmit);
        end
      end
      @(negedge clk);
      total++;
      if (timeout_err !== 1'b1 || ctrl_en !== 1'b0 ||
          busy !== 1'b0) begin
        bad++;
        $display("FAIL to_pulse err=%b en=%b busy=%b want 1 0 0",
                 timeout_err, ctrl_en, busy);
      end
      to_left--;
      to_seen++;
      return;
    end
    b = $urandom_range(1, 5);
    @(negedge clk);
    total++;
    if (transmit !== 1'b0) begin
      bad++;
      $display("FAIL tx_pulse got=%b want=0", transmit);
    end
    inter_ready = 0;
    repeat (b) begin
      @(negedge clk);
      total++;
      if (transmit !== 1'b0 || ctrl_en !== 1'b1 ||
          timeout_err !== 1'b0 || grant !== g[0] ||
          {ctrl_msg_type, ctrl_number} !== e) begin
        bad++;
        $display("FAIL wait_hold tx=%b en=%b err=%b f=%h want 0 1 0 %h",
                 transmit, ctrl_en, timeout_err,
                 {ctrl_msg_type, ctrl_number}, e);
      end
    end
    inter_ready = 1;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || ctrl_en !== 1'b0 || transmit !== 1'b0) begin
      bad++;
      $display("FAIL complete busy=%b en=%b tx=%b want 000",
               busy, ctrl_en, transmit);
    end
    if (g == 1) void'(q1.pop_front());
    else void'(q0.pop_front());
    mlast = g[0];
    done_cnt++;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (link_en && transmit === 1'b1) serve();
    end
  end

  task automatic push(input int r, input logic [7:0] d,
                      output bit acc);
    bit er;
    @(negedge clk);
    #1;
    er = (r == 1) ? (q1.size() != DEPTH) : (q0.size() != DEPTH);
    total++;
    if (r == 1) begin
      req1_valid = 1;
      {req1_msg_type, req1_number} = d;
      if (req1_ready !== er) begin
        bad++;
        $display("FAIL push_rdy1 got=%b want=%b", req1_ready, er);
      end
      if (er) q1.push_back('{d, cyc + 1});
    end else begin
      req0_valid = 1;
      {req0_msg_type, req0_number} = d;
      if (req0_ready !== er) begin
        bad++;
        $display("FAIL push_rdy0 got=%b want=%b", req0_ready, er);
      end
      if (er) q0.push_back('{d, cyc + 1});
    end
    acc = er;
    @(negedge clk);
    #1;
    req0_valid = 0;
    req1_valid = 0;
  endtask

  task automatic wait_done(input int target, input int budget);
    int n;
    n = 0;
    while (done_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    #1;
    total++;
    if (done_cnt < target) begin
      bad++;
      $display("FAIL wait_done got=%0d want=%0d", done_cnt, target);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    link_en = 0;
    req0_valid = 0;
    req1_valid = 0;
    rst = 0;
    repeat (2) @(negedge clk);
    #1;
    rst = 1;
    q0.delete();
    q1.delete();
    mlast = 1;
  endtask

  task automatic test_reset();
    logic [14:0] o;
    repeat (3) @(negedge clk);
    o = {transmit, ctrl_en, ctrl_msg_type, ctrl_number, busy,
         timeout_err, grant, req0_ready, req1_ready};
    total++;
    if (o !== 15'b000000000000011) begin
      bad++;
      $display("FAIL reset_vals got=%b want=000000000000011", o);
    end
    #1;
    rst = 1;
    inter_ready = 1;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || transmit !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle busy=%b tx=%b want 00", busy, transmit);
    end
  endtask

  task automatic test_single();
    bit acc;
    int d0;
    d0 = done_cnt;
    link_en = 1;
    inter_ready = 1;
    push(0, {3'd3, 5'd17}, acc);
    total++;
    if (transmit !== 1'b0) begin
      bad++;
      $display("FAIL lat_n1 got=%b want=0", transmit);
    end
    @(negedge clk);
    #1;
    total++;
    if (transmit !== 1'b1 || ctrl_msg_type !== 3'd3 ||
        ctrl_number !== 5'd17) begin
      bad++;
      $display("FAIL lat_n2 tx=%b t=%0d n=%0d want 1 3 17",
               transmit, ctrl_msg_type, ctrl_number);
    end
    wait_done(d0 + 1, 100);
    repeat (6) @(negedge clk);
    total++;
    if (busy !== 1'b0 || req0_ready !== 1'b1) begin
      bad++;
      $display("FAIL single_after busy=%b rdy=%b want 0 1",
               busy, req0_ready);
    end
  endtask

  task automatic test_round_robin();
    bit acc;
    int d0, m;
    bit [3:0] rr;
    rr = 4'b1010;
    do_reset();
    inter_ready = 0;
    push(0, 8'h21, acc);
    push(0, 8'h42, acc);
    push(1, 8'h63, acc);
    push(1, 8'h84, acc);
    m  = sent.size();
    d0 = done_cnt;
    inter_ready = 1;
    link_en = 1;
    wait_done(d0 + 4, 200);
    for (int k = 0; k < 4; k++) begin
      total++;
      if (sent.size() <= m + k || sent[m + k][8] !== rr[k]) begin
        bad++;
        $display("FAIL rr_order k=%0d want=%b", k, rr[k]);
      end
    end
  endtask

  task automatic test_full_wrap();
    bit acc;
    int d0, m, n;
    logic [7:0] d;
    logic [7:0] exp[$];
    link_en = 0;
    inter_ready = 0;
    m = sent.size();
    d0 = done_cnt;
    for (int k = 0; k < DEPTH; k++) begin
      d = 8'($urandom);
      push(1, d, acc);
      if (acc) exp.push_back(d);
    end
    #1;
    total++;
    if (req1_ready !== 1'b0) begin
      bad++;
      $display("FAIL full_rdy got=%b want=0", req1_ready);
    end
    push(1, 8'hEE, acc);
    total++;
    if (acc !== 1'b0 || q1.size() != DEPTH) begin
      bad++;
      $display("FAIL full_refuse acc=%b want=0", acc);
    end
    inter_ready = 1;
    link_en = 1;
    wait_done(d0 + 1, 100);
    for (int k = 0; k < 3; k++) begin
      d = 8'($urandom);
      n = 0;
      acc = 0;
      while (!acc && n < 40) begin
        push(1, d, acc);
        n++;
      end
      if (acc) exp.push_back(d);
    end
    wait_done(d0 + DEPTH + 3, 400);
    for (int k = 0; k < DEPTH + 3; k++) begin
      total++;
      if (sent.size() <= m + k || k >= exp.size() ||
          sent[m + k] !== {1'b1, exp[k]}) begin
        bad++;
        $display("FAIL wrap_order k=%0d want=%h", k,
                 (k < exp.size()) ? exp[k] : 8'h0);
      end
    end
  endtask

  task automatic test_timeout();
    bit acc;
    int d0, m, t0;
    logic [7:0] d;
    d  = 8'($urandom);
    m  = sent.size();
    d0 = done_cnt;
    t0 = to_seen;
    to_left = 1;
    push(0, d, acc);
    wait_done(d0 + 1, 200);
    total++;
    if (to_seen != t0 + 1) begin
      bad++;
      $display("FAIL to_count got=%0d want=%0d", to_seen, t0 + 1);
    end
    total++;
    if (sent.size() != m + 2 || sent[m] !== {1'b0, d} ||
        sent[m + 1] !== {1'b0, d}) begin
      bad++;
      $display("FAIL to_retry n=%0d want=%0d d=%h",
               sent.size() - m, 2, d);
    end
  endtask

  task automatic test_back_to_back();
    bit acc;
    int d0, na;
    d0 = done_cnt;
    na = 0;
    for (int k = 0; k < 150; k++) begin
      if ($urandom_range(0, 2) == 0) begin
        push(int'($urandom_range(0, 1)), 8'($urandom), acc);
        if (acc) na++;
      end else begin
        @(negedge clk);
      end
    end
    wait_done(d0 + na, 3000);
    total++;
    if (done_cnt != d0 + na) begin
      bad++;
      $display("FAIL rand_drain got=%0d want=%0d",
               done_cnt - d0, na);
    end
  endtask

  task automatic test_flush();
    bit acc;
    link_en = 0;
    inter_ready = 0;
    push(0, 8'h11, acc);
    push(1, 8'h22, acc);
    push(0, 8'h33, acc);
    @(negedge clk);
    #1;
    inter_ready = 1;
    @(negedge clk);
    #1;
    total++;
    if (transmit !== 1'b1) begin
      bad++;
      $display("FAIL flush_issue got=%b want=1", transmit);
    end
    inter_ready = 0;
    @(negedge clk);
    @(negedge clk);
    #1;
    total++;
    if (busy !== 1'b1 || ctrl_en !== 1'b1) begin
      bad++;
      $display("FAIL flush_pre busy=%b en=%b want 11", busy, ctrl_en);
    end
    irst = 1;
    @(negedge clk);
    #1;
    irst = 0;
    total++;
    if (ctrl_en !== 1'b0 || busy !== 1'b0 || transmit !== 1'b0) begin
      bad++;
      $display("FAIL flush_out en=%b busy=%b tx=%b want 000",
               ctrl_en, busy, transmit);
    end
    q0.delete();
    q1.delete();
    mlast = 1;
    inter_ready = 1;
    repeat (8) begin
      @(negedge clk);
      total++;
      if (transmit !== 1'b0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL flush_quiet tx=%b busy=%b want 00",
                 transmit, busy);
      end
    end
  endtask

  task automatic test_async_reset();
    bit acc;
    logic [14:0] o;
    link_en = 0;
    inter_ready = 1;
    push(0, 8'h5A, acc);
    @(negedge clk);
    #1;
    total++;
    if (transmit !== 1'b1) begin
      bad++;
      $display("FAIL ar_issue got=%b want=1", transmit);
    end
    #1;
    rst = 0;
    #1;
    o = {transmit, ctrl_en, ctrl_msg_type, ctrl_number, busy,
         timeout_err, grant, req0_ready, req1_ready};
    total++;
    if (o !== 15'b000000000000011) begin
      bad++;
      $display("FAIL ar_vals got=%b want=000000000000011", o);
    end
    @(negedge clk);
    #1;
    rst = 1;
    q0.delete();
    q1.delete();
    mlast = 1;
    repeat (5) begin
      @(negedge clk);
      total++;
      if (transmit !== 1'b0) begin
        bad++;
        $display("FAIL ar_quiet got=%b want=0", transmit);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_full_wrap();
    test_timeout();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
